// File: rtl/serializador_paralelo_serie.sv
// serializador_paralelo_serie: parallel-to-serial framer, MSB first, one-cycle load latency.
// Define SERIALIZADOR_PARITY_EN to append an even-parity bit after the LSB of each frame.
module serializador_paralelo_serie #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
`ifdef SERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par_q, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last, accept;
  always_comb begin
    last = state_q == SHIFT && cnt_q == '0;
`ifdef SERIALIZADOR_PARITY_EN
    done = state_q == PARITY;
    serial_out = state_q == PARITY ? par_q : state_q == SHIFT && sr_q[WIDTH-1];
    frame_valid = state_q != IDLE;
`else
    done = last;
    serial_out = state_q == SHIFT && sr_q[WIDTH-1];
    frame_valid = state_q == SHIFT;
`endif
    load_ready = state_q == IDLE || done;
    accept = load_valid && load_ready;
    sr_d = accept ? data_in : state_q == SHIFT ? sr_q << 1 : sr_q;
    // counter parks at zero on the last bit so it never wraps
    cnt_d = accept ? CW'(WIDTH - 1) : state_q == SHIFT && !last ? cnt_q - CW'(1) : cnt_q;
`ifdef SERIALIZADOR_PARITY_EN
    par_d = accept ? ^data_in : par_q;
    state_d = accept ? SHIFT : last ? PARITY : state_q == PARITY ? IDLE : state_q;
`else
    state_d = accept ? SHIFT : last ? IDLE : state_q;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_serializador_paralelo_serie.sv
// tb_serializador_paralelo_serie: vector table plus bit-stream scoreboard for the serializer (WIDTH=4).
module tb_serializador_paralelo_serie;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, serial_out, frame_valid, done;
  int         n_pass = 0, n_total = 0;
  typedef struct packed {logic b; logic d;} ent_t;
  typedef struct {logic lv; logic [3:0] d; logic chk; logic [3:0] exp;} vec_t;
  ent_t q[$];
  vec_t tbl[$];
`ifdef SERIALIZADOR_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  serializador_paralelo_serie #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .frame_valid(frame_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: {sout,fv,done,rdy} got=%b want=%b at %0t", nm, got, want, $time);
    else n_pass++;
  endtask

  // Sample the current cycle at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input logic lv, input logic [3:0] d, input logic chk, input logic [3:0] exp);
    logic [3:0] got, sb;
    logic rdy;
    @(negedge clk);
    got = {serial_out, frame_valid, done, load_ready};
    sb = q.size() != 0 ? {q[0].b, 1'b1, q[0].d, q.size() == 1} : 4'b0001;
    check("scoreboard", got, sb);
    if (chk) check("vector", got, exp);
    rdy = q.size() <= 1;
    if (q.size() != 0) void'(q.pop_front());
    load_valid = lv;
    data_in = d;
    if (lv && rdy) begin
      for (int i = 3; i >= 0; i--) q.push_back('{d[i], i == 0 && !PAR});
      if (PAR) q.push_back('{^d, 1'b1});
    end
  endtask

  initial begin
`ifdef SERIALIZADOR_PARITY_EN
    tbl.push_back('{1'b1, 4'b0111, 1'b1, 4'b0001});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1111});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0001});
`else
    tbl.push_back('{1'b1, 4'b1011, 1'b1, 4'b0001});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1111});
    tbl.push_back('{1'b1, 4'b1001, 1'b1, 4'b0001});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b1100});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b0100});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b0100});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 4'b1111});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0111});
    tbl.push_back('{1'b1, 4'b1100, 1'b1, 4'b0001});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b1100});
    tbl.push_back('{1'b1, 4'b0011, 1'b1, 4'b1100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0111});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0001});
`endif
    #1 check("reset_idle", {serial_out, frame_valid, done, load_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) step(tbl[i].lv, tbl[i].d, tbl[i].chk, tbl[i].exp);
    // abort a frame with an asynchronous reset in its second bit cycle
    step(1'b1, 4'b1111, 1'b0, 4'b0000);
    step(1'b0, 4'b0000, 1'b1, 4'b1100);
    step(1'b0, 4'b0000, 1'b1, 4'b1100);
    #2 rst = 1'b0;
    #1 check("async_reset", {serial_out, frame_valid, done, load_ready}, 4'b0001);
    q.delete();
    step(1'b0, 4'b0000, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, 1'b1, 4'b0001);
    rst = 1'b1;
    step(1'b1, 4'b0101, 1'b1, 4'b0001);
    step(1'b0, 4'b0000, 1'b1, 4'b0100);
    step(1'b0, 4'b0000, 1'b1, 4'b1100);
    step(1'b0, 4'b0000, 1'b1, 4'b0100);
    step(1'b0, 4'b0000, 1'b1, PAR ? 4'b1100 : 4'b1111);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 1'b0, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serializador_paralelo_serie.md
SERIALIZADOR_PARALELO_SERIE -- requirements
Module: serializador_paralelo_serie

Interface
REQ-001 Parameter: WIDTH, 4, payload bits per frame; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
REQ-004 Port: data_in  input  WIDTH  parallel word; sampled only on an accepted load.
REQ-005 Port: load_valid  input  1  upstream offers data_in.
REQ-006 Port: load_ready  output  1  block can accept a word this cycle.
REQ-007 Port: serial_out  output  1  serial bit stream, MSB first; feeds the downstream serial-in shift register D input.
REQ-008 Port: frame_valid  output  1  high while serial_out carries a frame bit.
REQ-009 Port: done  output  1  high during the cycle the last bit of a frame is driven.

Function
REQ-010 The block SHALL implement states IDLE, SHIFT and (PARITY_EN only) PARITY.
REQ-011 A load SHALL be accepted at a rising edge where load_valid=1 and load_ready=1; otherwise load_valid and data_in SHALL be ignored.
REQ-012 On acceptance: data_in copied to WIDTH-bit shift register, bit counter loaded with WIDTH-1, state goes to SHIFT.
REQ-013 Latency SHALL be 1 cycle: the frame MSB appears on serial_out in the cycle after the accepting edge.
REQ-014 In SHIFT, serial_out SHALL equal shift register bit WIDTH-1 and frame_valid SHALL be 1.
REQ-015 Each SHIFT edge SHALL shift left by one, filling bit 0 with 0, and decrement the counter.
REQ-016 SHIFT with counter=0 is the last payload cycle; next state PARITY if enabled, else IDLE (or SHIFT on a new load).
REQ-017 In IDLE, serial_out=0, frame_valid=0, done=0, load_ready=1.
REQ-018 load_ready SHALL be 1 in IDLE and in the final bit cycle of a frame, 0 otherwise.
REQ-019 A load accepted in the final bit cycle SHALL start the next frame with no gap (back-to-back frames, frame_valid continuously 1).
REQ-020 done SHALL be a one-cycle pulse per frame, asserted in the final bit cycle, combinational from state and counter.
REQ-021 Counter width SHALL be $clog2(WIDTH); no wrap below 0 is ever reached.

Reset
REQ-022 While rst=0: state IDLE, shift register 0, counter 0, serial_out=0, frame_valid=0, done=0, load_ready=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately with no partial completion or done pulse.
REQ-024 After rst deasserts, the first accepted load SHALL start a fresh frame at its MSB.

Configuration
REQ-025 Macro SERIALIZADOR_PARITY_EN defined: after the LSB, one PARITY cycle drives the even-parity bit (XOR of the accepted word) with frame_valid=1; frame length WIDTH+1; the PARITY cycle is the final bit cycle for REQ-018/019/020.
REQ-026 Macro undefined: no PARITY state or parity logic; frame length WIDTH; LSB cycle is the final bit cycle.

Verification (WIDTH=4)
REQ-027 Hold rst=0 mid-stimulus -> serial_out=0, frame_valid=0, done=0, load_ready=1 without a clock edge.
REQ-028 Load 4'b1011 at edge 0 -> cycles 1..4 serial_out 1,0,1,1, frame_valid=1; done and load_ready high in cycle 4 only; IDLE in cycle 5.
REQ-029 load_valid held, words 4'b1001 then 4'b0110 -> 8 contiguous frame_valid cycles, bits 1,0,0,1,0,1,1,0; done in cycles 4 and 8.
REQ-030 Load 4'b1100, pulse load_valid with 4'b0011 in cycle 2 -> ignored; stream 1,1,0,0 then IDLE.
REQ-031 Load 4'b1111, rst=0 in cycle 2 -> outputs reset at once, no done; after release load 4'b0101 -> 0,1,0,1.
REQ-032 SERIALIZADOR_PARITY_EN defined, load 4'b0111 -> 0,1,1,1 then parity 1; frame_valid 5 cycles; done in cycle 5 only.
